// File: rtl/sys_defs.sv
// Shared system-wide definitions: default occupancy of each shared functional unit
// and small elaboration-time helpers used by the unit arbiters.
package sys_defs;

    localparam int unsigned ALU_LATENCY           = 1;
    localparam int unsigned MUL_LATENCY           = 4;
    localparam int unsigned FPU_LATENCY           = 6;
    localparam int unsigned DIV_LATENCY           = 16;
    localparam int unsigned RR_DEFAULT_REQUESTERS = 8;

    // Down-counter width for a unit busy LATENCY cycles; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/onehot_to_therm.sv
// Converts a one-hot vector to a thermometer code. DIR=1 fills upward from the set bit
// (00001000 -> 11111000); DIR=0 fills downward (00001000 -> 00001111).
module onehot_to_therm #(
    parameter int unsigned N   = 8,
    parameter bit          DIR = 1'b1
) (
    input  logic [N-1:0] onehot_i,
    output logic [N-1:0] therm_o
);

    logic acc;

    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch is inferred.
        therm_o = '0;
        acc     = 1'b0;
        if (DIR) begin
            for (int i = 0; i < N; i++) begin
                acc        = acc | onehot_i[i];
                therm_o[i] = acc;
            end
        end else begin
            for (int i = N - 1; i >= 0; i--) begin
                acc        = acc | onehot_i[i];
                therm_o[i] = acc;
            end
        end
    end

endmodule

// File: rtl/rr_fu_arbiter.sv
// Round-robin arbiter for one shared functional unit that stays occupied for LATENCY
// cycles per operation; back-to-back grants with no idle bubble, flush squashes in flight.
module rr_fu_arbiter
    import sys_defs::*;
#(
    parameter int unsigned N       = RR_DEFAULT_REQUESTERS,
    parameter int unsigned LATENCY = MUL_LATENCY
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic [N-1:0] req_i,
    input  logic         flush_i,
    output logic [N-1:0] gnt_o,
    output logic [N-1:0] done_o,
    output logic         busy_o
);

    typedef enum logic {IDLE, BUSY} state_e;

    localparam int unsigned   CW        = cnt_width(LATENCY);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(LATENCY - 1);
    localparam logic [N-1:0]  PTR_RESET = {1'b1, {(N-1){1'b0}}};

    state_e        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [N-1:0]  ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  therm;
    logic [N-1:0]  eligible;
    logic [N-1:0]  masked;
    logic [N-1:0]  pick_src;
    logic [N-1:0]  pick;
    logic          completing;

    onehot_to_therm #(
        .N   (N),
        .DIR (1'b1)
    ) u_therm (
        .onehot_i (ptr_q),
        .therm_o  (therm)
    );

    // The finishing owner may still hold req this cycle; it must not win again.
    assign completing = (state_q == BUSY) && (cnt_q == '0) && !flush_i;
    assign eligible   = req_i & ~(completing ? gnt_q : '0);
    assign masked     = eligible & therm & ~ptr_q;
    assign pick_src   = (masked != '0) ? masked : eligible;
    assign pick       = pick_src & (~pick_src + N'(1));

    always_ff @(posedge clock_i) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= PTR_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = IDLE;
            gnt_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (eligible != '0) begin
                        state_d = BUSY;
                        gnt_d   = pick;
                        ptr_d   = pick;
                        cnt_d   = CNT_LOAD;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else if (eligible != '0) begin
                        gnt_d = pick;
                        ptr_d = pick;
                        cnt_d = CNT_LOAD;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q == BUSY);
        gnt_o  = gnt_q;
        done_o = completing ? gnt_q : '0;
    end

endmodule

// File: tb/tb_rr_fu_arbiter.sv
// Self-checking bench: directed scenarios with hand-derived expectations on an
// 8-requester / 4-cycle instance and a 1-cycle instance, plus randomized traffic vs a model.
module tb_rr_fu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req_a, req_b;
    logic       flush_a, flush_b;
    logic [7:0] gnt_a, done_a, gnt_b, done_b;
    logic       busy_a, busy_b;

    int n_pass  = 0;
    int n_total = 0;

    int m_owner[2];
    int m_rem[2];
    int m_ptr[2];
    int m_lat[2];

    logic [7:0] eg, ed;
    logic       eb;

    always #5 clk = ~clk;

    rr_fu_arbiter #(.N(8), .LATENCY(4)) dut_a (
        .clock_i (clk),
        .reset_i (rst),
        .req_i   (req_a),
        .flush_i (flush_a),
        .gnt_o   (gnt_a),
        .done_o  (done_a),
        .busy_o  (busy_a)
    );

    rr_fu_arbiter #(.N(8), .LATENCY(1)) dut_b (
        .clock_i (clk),
        .reset_i (rst),
        .req_i   (req_b),
        .flush_i (flush_b),
        .gnt_o   (gnt_b),
        .done_o  (done_b),
        .busy_o  (busy_b)
    );

    // Reference model: owner index (-1 idle), remaining cycles after this one, last winner.
    function automatic logic [7:0] exp_gnt(input int k);
        return (m_owner[k] >= 0) ? 8'(1 << m_owner[k]) : 8'h00;
    endfunction

    function automatic logic [7:0] exp_done(input int k, input logic fl);
        return (m_owner[k] >= 0 && m_rem[k] == 0 && !fl) ? exp_gnt(k) : 8'h00;
    endfunction

    function automatic void model_step(input int k, input logic r, input logic fl, input logic [7:0] rq);
        bit fin;
        int win;
        int idx;
        fin = (m_owner[k] >= 0) && (m_rem[k] == 0);
        win = -1;
        if (r) begin
            m_owner[k] = -1;
            m_ptr[k]   = 7;
            m_rem[k]   = 0;
        end else if (fl) begin
            m_owner[k] = -1;
            m_rem[k]   = 0;
        end else if (m_owner[k] < 0 || fin) begin
            for (int s = 1; s <= 8; s++) begin
                idx = (m_ptr[k] + s) % 8;
                if (win < 0 && rq[idx] && !(fin && idx == m_owner[k])) win = idx;
            end
            if (win >= 0) begin
                m_owner[k] = win;
                m_ptr[k]   = win;
                m_rem[k]   = m_lat[k] - 1;
            end else begin
                m_owner[k] = -1;
            end
        end else begin
            m_rem[k] = m_rem[k] - 1;
        end
    endfunction

    task automatic do_reset();
        rst = 1'b1; req_a = 8'h00; req_b = 8'h00; flush_a = 1'b0; flush_b = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_a = 8'hFF; req_b = 8'hFF; flush_a = 1'b1; flush_b = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_a = 8'h00; req_b = 8'h00; flush_a = 1'b0; flush_b = 1'b0;
        @(negedge clk);
        n_total++;
        if ({gnt_a, done_a, busy_a} !== 17'h0)
            $display("FAIL reset_a: gnt=%h done=%h busy=%b expected all zero", gnt_a, done_a, busy_a);
        else n_pass++;
        n_total++;
        if ({gnt_b, done_b, busy_b} !== 17'h0)
            $display("FAIL reset_b: gnt=%h done=%h busy=%b expected all zero", gnt_b, done_b, busy_b);
        else n_pass++;
        req_a = 8'hFF;
        @(posedge clk); #1;
        @(negedge clk);
        n_total++;
        if ({gnt_a, busy_a} !== {8'h01, 1'b1})
            $display("FAIL reset_first_winner: gnt=%h busy=%b expected gnt=01 busy=1", gnt_a, busy_a);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        req_a = 8'h05;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            req_a = (c <= 4) ? 8'h05 : (c <= 8) ? 8'h04 : 8'h00;
            @(negedge clk);
            eg = (c <= 4) ? 8'h01 : (c <= 8) ? 8'h04 : 8'h00;
            ed = (c == 4) ? 8'h01 : (c == 8) ? 8'h04 : 8'h00;
            eb = (c <= 8);
            n_total++;
            if ({gnt_a, done_a, busy_a} !== {eg, ed, eb})
                $display("FAIL back_to_back c%0d: gnt=%h done=%h busy=%b expected gnt=%h done=%h busy=%b",
                         c, gnt_a, done_a, busy_a, eg, ed, eb);
            else n_pass++;
        end
    endtask

    task automatic test_alternate();
        do_reset();
        req_a = 8'h81;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            eg = (((c - 1) / 4) % 2 == 0) ? 8'h01 : 8'h80;
            ed = (c % 4 == 0) ? eg : 8'h00;
            eb = 1'b1;
            n_total++;
            if ({gnt_a, done_a, busy_a} !== {eg, ed, eb})
                $display("FAIL alternate c%0d: gnt=%h done=%h busy=%b expected gnt=%h done=%h busy=%b",
                         c, gnt_a, done_a, busy_a, eg, ed, eb);
            else n_pass++;
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        req_a = 8'h08;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (c == 7) req_a = 8'h00;
            @(negedge clk);
            eg = (c <= 4 || (c >= 6 && c <= 9)) ? 8'h08 : 8'h00;
            ed = (c == 4 || c == 9) ? 8'h08 : 8'h00;
            eb = (eg != 8'h00);
            n_total++;
            if ({gnt_a, done_a, busy_a} !== {eg, ed, eb})
                $display("FAIL single_req c%0d: gnt=%h done=%h busy=%b expected gnt=%h done=%h busy=%b",
                         c, gnt_a, done_a, busy_a, eg, ed, eb);
            else n_pass++;
        end
    endtask

    task automatic test_flush();
        do_reset();
        req_a = 8'h20;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            flush_a = (c == 2 || c == 7);
            req_a   = (c <= 2) ? 8'h20 : (c == 3) ? 8'h21 : (c <= 7) ? 8'h01 : (c == 8) ? 8'h21 : 8'h00;
            @(negedge clk);
            eg = (c <= 2) ? 8'h20 : (c == 3 || c == 8) ? 8'h00 : (c <= 7) ? 8'h01 : 8'h20;
            ed = 8'h00;
            eb = (eg != 8'h00);
            n_total++;
            if ({gnt_a, done_a, busy_a} !== {eg, ed, eb})
                $display("FAIL flush c%0d: gnt=%h done=%h busy=%b expected gnt=%h done=%h busy=%b",
                         c, gnt_a, done_a, busy_a, eg, ed, eb);
            else n_pass++;
        end
        flush_a = 1'b0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        req_a = 8'h04;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            rst   = (c == 3);
            req_a = (c <= 2) ? 8'h04 : 8'h09;
            @(negedge clk);
            eg = (c <= 3) ? 8'h04 : (c == 4) ? 8'h00 : 8'h01;
            ed = 8'h00;
            eb = (eg != 8'h00);
            n_total++;
            if ({gnt_a, done_a, busy_a} !== {eg, ed, eb})
                $display("FAIL reset_mid c%0d: gnt=%h done=%h busy=%b expected gnt=%h done=%h busy=%b",
                         c, gnt_a, done_a, busy_a, eg, ed, eb);
            else n_pass++;
        end
    endtask

    task automatic test_latency1();
        do_reset();
        req_b = 8'h06;
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk); #1;
            req_b = (c == 1) ? 8'h06 : (c == 2) ? 8'h04 : 8'h00;
            @(negedge clk);
            eg = (c == 1) ? 8'h02 : (c == 2) ? 8'h04 : 8'h00;
            ed = eg;
            eb = (c <= 2);
            n_total++;
            if ({gnt_b, done_b, busy_b} !== {eg, ed, eb})
                $display("FAIL latency1 c%0d: gnt=%h done=%h busy=%b expected gnt=%h done=%h busy=%b",
                         c, gnt_b, done_b, busy_b, eg, ed, eb);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        @(posedge clk); #1;
        for (int c = 0; c < 1500; c++) begin
            rst     = (c == 0) || ($urandom_range(0, 99) == 0);
            req_a   = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            req_b   = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            flush_a = ($urandom_range(0, 19) == 0);
            flush_b = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            if (c > 0) begin
                eg = exp_gnt(0); ed = exp_done(0, flush_a); eb = (m_owner[0] >= 0);
                n_total++;
                if ({gnt_a, done_a, busy_a} !== {eg, ed, eb})
                    $display("FAIL random_a c%0d: gnt=%h done=%h busy=%b expected gnt=%h done=%h busy=%b",
                             c, gnt_a, done_a, busy_a, eg, ed, eb);
                else n_pass++;
                eg = exp_gnt(1); ed = exp_done(1, flush_b); eb = (m_owner[1] >= 0);
                n_total++;
                if ({gnt_b, done_b, busy_b} !== {eg, ed, eb})
                    $display("FAIL random_b c%0d: gnt=%h done=%h busy=%b expected gnt=%h done=%h busy=%b",
                             c, gnt_b, done_b, busy_b, eg, ed, eb);
                else n_pass++;
                n_total++;
                if ($countones(gnt_a) > 1 || $countones(done_a) > 1 ||
                    $countones(gnt_b) > 1 || $countones(done_b) > 1)
                    $display("FAIL onehot c%0d: gnt_a=%h done_a=%h gnt_b=%h done_b=%h expected at most one bit each",
                             c, gnt_a, done_a, gnt_b, done_b);
                else n_pass++;
            end
            @(posedge clk);
            model_step(0, rst, flush_a, req_a);
            model_step(1, rst, flush_b, req_b);
            #1;
        end
        rst = 1'b0; req_a = 8'h00; req_b = 8'h00; flush_a = 1'b0; flush_b = 1'b0;
    endtask

    initial begin
        m_lat[0] = 4; m_lat[1] = 1;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_rem[k] = 0; m_ptr[k] = 7;
        end
        rst = 1'b1; req_a = 8'h00; req_b = 8'h00; flush_a = 1'b0; flush_b = 1'b0;
        test_reset();
        test_back_to_back();
        test_alternate();
        test_single_requester();
        test_flush();
        test_reset_mid_op();
        test_latency1();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
